led_update_sched: RTL and testbench

// - Frame scheduler upstream of led_driver: owns ping-pong frame-buffer selection and the LED refresh rate.
// - The producer (renderer) fills the back buffer and reports completion.
// - On each frame tick the scheduler swaps front/back, pulses ctrl_update with ctrl_buf_id = new front, and waits for ctrl_update_done.

---
 rtl/led_update_sched_pkg.sv | 19 +
 rtl/led_update_sched_if.sv | 26 ++
 rtl/led_update_sched_frame_timer.sv | 36 +++
 rtl/led_update_sched.sv | 126 ++++++++++++
 tb/tb_led_update_sched.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/led_update_sched_pkg.sv
// Shared definitions for the LED frame scheduler: FSM state encoding,
// default ping-pong buffer ids and the width of the completed-frame counter.
`default_nettype none

package led_update_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_e;

  localparam int unsigned DEF_BUF0_ID = 0;
  localparam int unsigned DEF_BUF1_ID = 1;
  localparam int unsigned FRAME_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/led_update_sched_if.sv
// Producer / led_driver handshake bundle for led_update_sched.
// The slave modport is the scheduler side.
`default_nettype none

interface led_update_sched_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  wr_frame_done;
  logic [DATA_WIDTH-1:0] wr_buf_id;
  logic                  wr_buf_free;
  logic                  ctrl_update;
  logic [DATA_WIDTH-1:0] ctrl_buf_id;
  logic                  ctrl_update_done;

  modport master (
    output wr_frame_done, ctrl_update_done,
    input  wr_buf_id, wr_buf_free, ctrl_update, ctrl_buf_id
  );

  modport slave (
    input  wr_frame_done, ctrl_update_done,
    output wr_buf_id, wr_buf_free, ctrl_update, ctrl_buf_id
  );
endinterface

`default_nettype wire

// File: rtl/led_update_sched_frame_timer.sv
// Frame tick generator: counts 0..FRAME_CYCLES-1 while enabled and pulses
// o_tick on the last count; i_clear returns the count to zero.
`default_nettype none

module led_update_sched_frame_timer #(
  parameter int unsigned FRAME_CYCLES = 2_000_000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_enable,
  input  wire logic i_clear,
  output logic      o_tick
);

  localparam int unsigned         CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_LAST);
  assign o_tick = i_enable & ~i_clear & w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_update_sched.sv
// Ping-pong frame scheduler feeding led_driver: swaps front/back on frame ticks.
// Optional update watchdog enabled by defining LED_SCHED_WDOG_EN.
`default_nettype none

module led_update_sched
  import led_update_sched_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter int unsigned          FRAME_CYCLES = 2_000_000,
  parameter logic [DATA_WIDTH-1:0] BUF0_ID     = DATA_WIDTH'(DEF_BUF0_ID),
  parameter logic [DATA_WIDTH-1:0] BUF1_ID     = DATA_WIDTH'(DEF_BUF1_ID),
  parameter int unsigned          WDOG_CYCLES  = 4_000_000
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_enable,
  input  wire logic              i_err_clr,
  led_update_sched_if.slave      bus,
  output logic                   o_busy,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic                   o_frame_overrun,
  output logic                   o_err_timeout
);

  sched_state_e           r_state, w_state_nxt;
  logic                   r_front, r_back_full, r_pend_tick;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_overrun, r_err_timeout;
  logic                   w_tick, w_swap, w_done, w_timeout, w_wdog_hit;

  led_update_sched_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_enable (i_enable),
    .i_clear  (~i_enable),
    .o_tick   (w_tick)
  );

`ifdef LED_SCHED_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  // Counts cycles since the ctrl_update pulse; 1 on the first WAIT_DONE cycle.
  logic [WDOG_W-1:0] r_wdog_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_wdog_cnt <= WDOG_W'(1);
    end else if (r_state == ST_WAIT_DONE) begin
      r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
    end
  end

  assign w_wdog_hit = (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  // No watchdog in this build; WDOG_CYCLES has no effect.
  assign w_wdog_hit = 1'b0 & (WDOG_CYCLES != 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_tick | r_pend_tick) & r_back_full & i_enable) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.ctrl_update_done) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_wdog_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_front       <= 1'b0;
      r_back_full   <= 1'b0;
      r_pend_tick   <= 1'b0;
      r_frame_cnt   <= '0;
      r_overrun     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap) r_front <= ~r_front;
      // Swap decision sees the registered flag, so a coincident frame_done waits for the next tick.
      if (w_swap) r_back_full <= 1'b0;
      else if (bus.wr_frame_done) r_back_full <= 1'b1;
      // Any IDLE cycle consumes a pending tick, whether or not it produced an update.
      if (!i_enable || r_state == ST_IDLE) r_pend_tick <= 1'b0;
      else if (w_tick) r_pend_tick <= 1'b1;
      if (w_done) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      if (w_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
      else if (i_err_clr) r_overrun <= 1'b0;
      if (w_timeout) r_err_timeout <= 1'b1;
      else if (i_err_clr) r_err_timeout <= 1'b0;
    end
  end

  assign bus.ctrl_update = (r_state == ST_START);
  assign bus.ctrl_buf_id = r_front ? BUF1_ID : BUF0_ID;
  assign bus.wr_buf_id   = r_front ? BUF0_ID : BUF1_ID;
  assign bus.wr_buf_free = ~r_back_full;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_frame_cnt     = r_frame_cnt;
  assign o_frame_overrun = r_overrun;
  assign o_err_timeout   = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_led_update_sched.sv
// Bench for led_update_sched: directed scenarios plus random traffic, all
// checked each cycle against a cycle-level behavioural model of the scheduler.
`default_nettype none

module tb_led_update_sched;
  localparam int FRAME = 100;
  localparam int WDOG  = 200;
`ifdef LED_SCHED_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy, overrun, err_to;
  logic [15:0] frame_cnt;

  led_update_sched_if #(.DATA_WIDTH(32)) bus ();

  led_update_sched #(
    .DATA_WIDTH   (32),
    .FRAME_CYCLES (FRAME),
    .BUF0_ID      (32'd0),
    .BUF1_ID      (32'd1),
    .WDOG_CYCLES  (WDOG)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_enable        (en),
    .i_err_clr       (err_clr),
    .bus             (bus),
    .o_busy          (busy),
    .o_frame_cnt     (frame_cnt),
    .o_frame_overrun (overrun),
    .o_err_timeout   (err_to)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses;

  // Model: frame timer position, which buffer is shown, whether the back
  // buffer holds a finished frame, and the age of the in-flight update.
  int m_tcnt, m_age, m_cnt;
  bit m_front, m_full, m_pend, m_busy, m_ovr, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tcnt = 0; m_age = 0; m_cnt = 0;
    m_front = 0; m_full = 0; m_pend = 0; m_busy = 0; m_ovr = 0; m_err = 0;
  endtask

  task automatic model_next(input bit e, input bit w, input bit d, input bit c);
    bit tick, swap, set_ovr, set_err;
    tick = e && (m_tcnt == FRAME - 1);
    m_tcnt = !e ? 0 : (tick ? 0 : m_tcnt + 1);
    swap = 0; set_ovr = 0; set_err = 0;
    if (!m_busy) begin
      if ((tick || m_pend) && m_full && e) begin
        swap = 1; m_busy = 1; m_age = 0;
      end
      m_pend = 0;
    end else begin
      if (tick) begin m_pend = 1; set_ovr = 1; end
      if (m_age >= 1 && d) begin
        m_busy = 0; m_cnt = (m_cnt + 1) % 65536;
      end else if (WD && m_age >= 1 && m_age == WDOG - 1) begin
        m_busy = 0; set_err = 1;
      end else begin
        m_age++;
      end
    end
    if (!e) m_pend = 0;
    if (swap) m_full = 0;
    else if (w) m_full = 1;
    if (swap) m_front = !m_front;
    m_ovr = set_ovr ? 1'b1 : (c ? 1'b0 : m_ovr);
    m_err = set_err ? 1'b1 : (c ? 1'b0 : m_err);
  endtask

  task automatic compare_all();
    chk("ctrl_update", 32'(bus.ctrl_update), 32'(m_busy && m_age == 0));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ctrl_buf_id", bus.ctrl_buf_id, m_front ? 32'd1 : 32'd0);
    chk("wr_buf_id", bus.wr_buf_id, m_front ? 32'd0 : 32'd1);
    chk("wr_buf_free", 32'(bus.wr_buf_free), 32'(!m_full));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("frame_overrun", 32'(overrun), 32'(m_ovr));
    chk("err_timeout", 32'(err_to), 32'(m_err));
  endtask

  // One clock: drive inputs mid-cycle, advance the model, observe after the edge.
  task automatic step(input bit e, input bit w, input bit d, input bit c);
    @(negedge clk);
    en = e; bus.wr_frame_done = w; bus.ctrl_update_done = d; err_clr = c;
    model_next(e, w, d, c);
    @(posedge clk);
    #1;
    if (bus.ctrl_update) pulses++;
    compare_all();
  endtask

  initial begin
    bus.wr_frame_done = 1'b0;
    bus.ctrl_update_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    compare_all();
    chk("rst_wr_buf_id", bus.wr_buf_id, 32'd1);
    chk("rst_ctrl_buf_id", bus.ctrl_buf_id, 32'd0);

    // Enabled with no frames: ticks are dropped, nothing is sent.
    pulses = 0;
    for (int i = 0; i < 500; i++) step(1, 0, 0, 0);
    chk("t1_no_update", 32'(pulses), 32'd0);
    chk("t1_wr_buf_free", 32'(bus.wr_buf_free), 32'd1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd0);

    // Timer restarted so ticks land on i = 99, 199, 299, 399.
    step(0, 0, 0, 0);
    for (int i = 0; i < 410; i++) begin
      step(1, i == 10 || i == 140 || i == 210 || i == 390 || i == 395,
              i == 130 || i == 350 || i == 380, i == 385);
      if (i == 390) pulses = 0;
      case (i)
        99: begin
          chk("t2_upd_after_tick", 32'(bus.ctrl_update), 32'd1);
          chk("t2_ctrl_buf_id", bus.ctrl_buf_id, 32'd1);
          chk("t2_wr_buf_id", bus.wr_buf_id, 32'd0);
        end
        130: begin
          chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
          chk("t2_busy", 32'(busy), 32'd0);
          chk("t2_wr_buf_free", 32'(bus.wr_buf_free), 32'd1);
        end
        199: chk("t3_first_id", bus.ctrl_buf_id, 32'd0);
        299: chk("t3_overrun", 32'(overrun), 32'd1);
        350: chk("t3_idle", 32'(busy), 32'd0);
        351: begin
          chk("t3_late_upd", 32'(bus.ctrl_update), 32'd1);
          chk("t3_late_id", bus.ctrl_buf_id, 32'd1);
        end
        385: chk("t3_err_clr", 32'(overrun), 32'd0);
        390: chk("t4_full_1", 32'(bus.wr_buf_free), 32'd0);
        395: chk("t4_full_2", 32'(bus.wr_buf_free), 32'd0);
        399: begin
          chk("t4_upd", 32'(bus.ctrl_update), 32'd1);
          chk("t4_id", bus.ctrl_buf_id, 32'd0);
          chk("t4_free_after", 32'(bus.wr_buf_free), 32'd1);
        end
        default: ;
      endcase
    end
    chk("t4_one_pulse", 32'(pulses), 32'd1);
    chk("t6_pre_busy", 32'(busy), 32'd1);

    // Asynchronous reset while waiting for the driver.
    en = 0; bus.wr_frame_done = 0; bus.ctrl_update_done = 0; err_clr = 0;
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ctrl_buf_id", bus.ctrl_buf_id, 32'd0);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Driver never answers: watchdog (when built) gives up after WDOG cycles.
    for (int i = 0; i < 320; i++) begin
      step(1, i == 5, i == 305, i == 310);
      if (i == 99) chk("t5_upd", 32'(bus.ctrl_update), 32'd1);
      if (i == 298) chk("t5_pre_err", 32'(err_to), 32'd0);
      if (i == 299) begin
        chk("t5_err", 32'(err_to), 32'(WD));
        chk("t5_busy", 32'(busy), 32'(!WD));
      end
      if (i == 310) chk("t5_err_clr", 32'(err_to), 32'd0);
    end

    begin
      int off = 0;
      bit slow = 0;
      for (int i = 0; i < 4000; i++) begin
        if (i % 256 == 0) slow = ($urandom_range(0, 2) == 0);
        if (off > 0) off--;
        else if ($urandom_range(0, 399) == 0) off = $urandom_range(1, 30);
        step(off == 0, $urandom_range(0, 29) == 0,
             slow ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 7) == 0),
             $urandom_range(0, 149) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
